// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier covering the four RISC-V M-extension multiply modes.
// Operands are converted to magnitudes and multiplied one bit per cycle with a
// single adder. The sign is applied in a final fix-up cycle.
module seq_multiplier #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               kill,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   operator_1,
  input  logic [WIDTH-1:0]   operator_2,
  output logic               busy,
  output logic               valid,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   answer
);

  localparam int unsigned IdxW = $clog2(WIDTH);
  localparam int unsigned CntW = IdxW + 1;
  localparam logic [CntW-1:0]    LastCnt = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0]    CntOne  = CntW'(1);
  localparam logic [WIDTH-1:0]   OneW    = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] OneP    = (2 * WIDTH)'(1);

  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    counter_q, counter_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [WIDTH-1:0]   answer_q, answer_d;
  logic [1:0]         mode_q, mode_d;
  logic               neg_q, neg_d;

  logic               op1_neg, op2_neg;
  logic [WIDTH-1:0]   op1_mag, op2_mag;
  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] final_val;

  // Decode operand signedness from the requested mode and form magnitudes.
  // The most negative value maps to 2^(WIDTH-1), which is exact as unsigned.
  always_comb begin
    op1_neg = ((mode == 2'b01) || (mode == 2'b10)) && operator_1[WIDTH-1];
    op2_neg = (mode == 2'b01) && operator_2[WIDTH-1];
    op1_mag = op1_neg ? (~operator_1 + OneW) : operator_1;
    op2_mag = op2_neg ? (~operator_2 + OneW) : operator_2;
  end

  // Partial product for the current multiplier bit and the sign-corrected result.
  always_comb begin
    addend    = {{WIDTH{1'b0}}, mcand_q} << counter_q;
    final_val = neg_q ? (~acc_q + OneP) : acc_q;
  end

  // Next-state and datapath updates; kill wins over everything in RUN/FIX.
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    product_d = product_q;
    answer_d  = answer_q;
    mode_d    = mode_q;
    neg_d     = neg_q;
    unique case (state_q)
      StIdle, StDone: begin
        // In DONE, kill suppresses a back-to-back launch; in IDLE it is ignored.
        if (start && !(kill && (state_q == StDone))) begin
          mode_d    = mode;
          mcand_d   = op1_mag;
          mplier_d  = op2_mag;
          neg_d     = op1_neg ^ op2_neg;
          acc_d     = '0;
          counter_d = '0;
          state_d   = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        if (kill) begin
          state_d = StIdle;
        end else begin
          if (mplier_q[counter_q[IdxW-1:0]]) begin
            acc_d = acc_q + addend;
          end
          counter_d = counter_q + CntOne;
          if (counter_q == LastCnt) begin
            state_d = StFix;
          end
        end
      end
      StFix: begin
        if (kill) begin
          state_d = StIdle;
        end else begin
          acc_d     = final_val;
          product_d = final_val;
          answer_d  = (mode_q == 2'b00) ? final_val[WIDTH-1:0] : final_val[2*WIDTH-1:WIDTH];
          state_d   = StDone;
        end
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      counter_q <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      product_q <= '0;
      answer_q  <= '0;
      mode_q    <= '0;
      neg_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      answer_q  <= answer_d;
      mode_q    <= mode_d;
      neg_q     <= neg_d;
    end
  end

  assign busy    = (state_q == StRun) || (state_q == StFix);
  assign valid   = (state_q == StDone);
  assign product = product_q;
  assign answer  = answer_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: WIDTH=32 and WIDTH=8 instances, randomized
// operands checked against a plain signed/unsigned arithmetic reference.
module tb_seq_multiplier;

  localparam int W  = 32;
  localparam int W8 = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          start, kill, busy, valid;
  logic [1:0]    mode;
  logic [W-1:0]  op1, op2, answer;
  logic [2*W-1:0] product;

  logic           start8, kill8, busy8, valid8;
  logic [1:0]     mode8;
  logic [W8-1:0]  a8, b8, answer8;
  logic [2*W8-1:0] product8;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .kill(kill), .mode(mode),
    .operator_1(op1), .operator_2(op2), .busy(busy), .valid(valid),
    .product(product), .answer(answer)
  );

  seq_multiplier #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .kill(kill8), .mode(mode8),
    .operator_1(a8), .operator_2(b8), .busy(busy8), .valid(valid8),
    .product(product8), .answer(answer8)
  );

  typedef struct {
    logic [127:0] prod;
    logic [127:0] ans;
    int           due;
  } exp_t;

  exp_t         q32[$];
  exp_t         q8[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           cyc = 0;
  logic [127:0] last_ans, last_prod;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: interpret operands per mode as integers and multiply.
  function automatic logic [127:0] ref_mul(input int w, input logic [1:0] m,
                                           input logic [63:0] a, input logic [63:0] b);
    logic signed [129:0] sa, sb, p;
    sa = $signed({66'd0, a});
    sb = $signed({66'd0, b});
    if ((m == 2'b01 || m == 2'b10) && a[w-1]) sa = sa - (130'sd1 <<< w);
    if (m == 2'b01 && b[w-1]) sb = sb - (130'sd1 <<< w);
    p = sa * sb;
    return p[127:0] & ((128'd1 << (2 * w)) - 128'd1);
  endfunction

  function automatic logic [127:0] ref_ans(input int w, input logic [1:0] m,
                                           input logic [127:0] p);
    logic [127:0] mask;
    mask = (128'd1 << w) - 128'd1;
    return (m == 2'b00) ? (p & mask) : ((p >> w) & mask);
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: every valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (valid) begin
      if (q32.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid32: got valid=1 required 0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q32.pop_front();
        chk("product32", product, e.prod);
        chk("answer32", answer, e.ans);
        chk("latency32", cyc, e.due);
        chk("busy_at_valid32", busy, 0);
      end
    end
  end

  always @(negedge clk) begin
    if (valid8) begin
      if (q8.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid8: got valid=1 required 0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q8.pop_front();
        chk("product8", product8, e.prod);
        chk("answer8", answer8, e.ans);
        chk("latency8", cyc, e.due);
      end
    end
  end

  // Drive a start for one cycle; optionally skip the leading wait to launch in place.
  task automatic launch32(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                          input bit push, input bit now);
    exp_t e;
    if (!now) @(negedge clk);
    start = 1'b1;
    mode  = m;
    op1   = a;
    op2   = b;
    if (push) begin
      e.prod = ref_mul(W, m, {32'd0, a}, {32'd0, b});
      e.ans  = ref_ans(W, m, e.prod);
      e.due  = cyc + W + 2;
      q32.push_back(e);
      last_ans  = e.ans;
      last_prod = e.prod;
    end
    @(negedge clk);
    start = 1'b0;
    op1   = $urandom;
    op2   = $urandom;
    mode  = 2'($urandom);
  endtask

  task automatic launch8(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    @(negedge clk);
    start8 = 1'b1;
    mode8  = m;
    a8     = a;
    b8     = b;
    e.prod = ref_mul(W8, m, {56'd0, a}, {56'd0, b});
    e.ans  = ref_ans(W8, m, e.prod);
    e.due  = cyc + W8 + 2;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
    a8     = 8'($urandom);
    b8     = 8'($urandom);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q32.size() != 0 || q8.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending required 0", q32.size() + q8.size());
      q32.delete();
      q8.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_valid32();
    int n;
    n = 0;
    while (!valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_valid32: got valid=0 required 1 within 100 cycles");
    end
  endtask

  initial begin
    start = 0; kill = 0; mode = 0; op1 = 0; op2 = 0;
    start8 = 0; kill8 = 0; mode8 = 0; a8 = 0; b8 = 0;
    rst = 0;
    #1 rst = 1;
    #2;
    chk("reset_busy", busy, 0);
    chk("reset_valid", valid, 0);
    chk("reset_product", product, 0);
    chk("reset_answer", answer, 0);
    @(negedge clk);
    rst = 0;

    // Directed cases with independently known results.
    launch32(2'b00, 32'd7, 32'd6, 1, 0);
    wait_drain();
    chk("mul_7x6_answer", answer, 32'h2A);
    chk("mul_7x6_product", product, 64'h2A);
    launch32(2'b01, 32'h8000_0000, 32'h8000_0000, 1, 0);
    wait_drain();
    chk("mulh_min_product", product, 64'h4000_0000_0000_0000);
    launch32(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0);
    wait_drain();
    chk("mulh_m1_product", product, 64'h1);
    launch32(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0);
    wait_drain();
    chk("mulhsu_product", product, 64'hFFFF_FFFF_0000_0001);
    launch32(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0);
    wait_drain();
    chk("mulhu_answer", answer, 32'hFFFF_FFFE);

    // Start while busy is ignored.
    launch32(2'b00, 32'd3, 32'd5, 1, 0);
    repeat (10) @(negedge clk);
    chk("busy_in_run", busy, 1);
    start = 1; op1 = 9; op2 = 9; mode = 0;
    @(negedge clk);
    start = 0;
    wait_drain();
    chk("ignored_start_answer", answer, 32'd15);

    // Back-to-back launch from DONE.
    launch32(2'b00, 32'd3, 32'd5, 1, 0);
    wait_valid32();
    launch32(2'b00, 32'd9, 32'd9, 1, 1);
    wait_drain();
    chk("b2b_answer", answer, 32'd81);

    // Kill mid-RUN: no valid, outputs retained.
    launch32(2'b01, 32'd3, 32'd4, 0, 0);
    repeat (5) @(negedge clk);
    kill = 1;
    @(negedge clk);
    kill = 0;
    chk("busy_after_kill", busy, 0);
    chk("answer_after_kill", answer, last_ans);
    chk("product_after_kill", product, last_prod);
    repeat (45) @(negedge clk);

    // Reset mid-RUN clears everything at once.
    launch32(2'b11, $urandom, $urandom, 0, 0);
    repeat (8) @(negedge clk);
    rst = 1;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_valid", valid, 0);
    chk("rst_mid_product", product, 0);
    chk("rst_mid_answer", answer, 0);
    @(negedge clk);
    rst = 0;
    repeat (40) @(negedge clk);
    launch32(2'b01, 32'hFFFF_FFF9, 32'd6, 1, 0);
    wait_drain();
    chk("after_rst_answer", answer, 32'hFFFF_FFFF);

    // Randomized traffic with ignored starts and occasional back-to-back launches.
    for (int i = 0; i < 30; i++) begin
      int n;
      launch32(2'($urandom), pick32(), pick32(), 1, 0);
      n = $urandom_range(0, 20);
      repeat (n) begin
        @(negedge clk);
        start = 1'($urandom);
        op1   = $urandom;
        op2   = $urandom;
        mode  = 2'($urandom);
      end
      start = 0;
      if ($urandom_range(0, 1) == 1) begin
        wait_valid32();
        launch32(2'($urandom), pick32(), pick32(), 1, 1);
      end
      wait_drain();
    end

    // Narrow instance.
    launch8(2'b01, 8'h80, 8'h7F);
    wait_drain();
    chk("w8_mulh_product", product8, 16'hC080);
    chk("w8_mulh_answer", answer8, 8'hC0);
    for (int i = 0; i < 12; i++) begin
      launch8(2'($urandom), 8'($urandom), 8'($urandom));
      wait_drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
